disparity_wta: RTL and testbench

DISPARITY_WTA -- requirements
Module: disparity_wta

---
 rtl/disparity_wta.sv | 109 ++++++++++
 tb/tb_disparity_wta.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector: streams per-disparity Hamming costs for a
// pixel and emits the lowest-cost disparity (ties keep the lower index).
module disparity_wta #(
  parameter int COST_WIDTH = 6,
  parameter int MAX_DISP   = 64,
  parameter int DISP_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cost_valid,
  input  logic [COST_WIDTH-1:0] cost,
  input  logic                  cost_last,
  output logic                  cost_ready,
  output logic                  disp_valid,
  output logic [DISP_WIDTH-1:0] disp,
  output logic [COST_WIDTH-1:0] min_cost,
  input  logic                  disp_ready,
  output logic                  len_err
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [DISP_WIDTH-1:0] LAST_IDX = DISP_WIDTH'(MAX_DISP - 1);

  state_t                state_q, state_d;
  logic [DISP_WIDTH-1:0] cnt_q, cnt_d;
  logic [COST_WIDTH-1:0] best_cost_q, best_cost_d;
  logic [DISP_WIDTH-1:0] best_disp_q, best_disp_d;
  logic                  valid_q, valid_d;
  logic [DISP_WIDTH-1:0] disp_q, disp_d;
  logic [COST_WIDTH-1:0] mcost_q, mcost_d;
  logic                  len_err_q, len_err_d;

  logic                  accept;
  logic                  at_limit;
  logic                  take;
  logic [COST_WIDTH-1:0] cand_cost;
  logic [DISP_WIDTH-1:0] cand_disp;

  // Only a held, unconsumed result back-pressures the input; a drain cycle still accepts.
  assign cost_ready = !(valid_q && !disp_ready);
  assign accept     = cost_valid && cost_ready;
  assign at_limit   = (cnt_q == LAST_IDX);
  assign take       = (state_q == IDLE) || (cost < best_cost_q);
  assign cand_cost  = take ? cost : best_cost_q;
  assign cand_disp  = take ? ((state_q == IDLE) ? '0 : cnt_q) : best_disp_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    best_cost_d = best_cost_q;
    best_disp_d = best_disp_q;
    valid_d     = valid_q;
    disp_d      = disp_q;
    mcost_d     = mcost_q;
    len_err_d   = len_err_q;

    if (valid_q && disp_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      best_cost_d = cand_cost;
      best_disp_d = cand_disp;
      // Hitting the last legal index closes the pixel even without cost_last.
      if (cost_last || at_limit) begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
        disp_d  = cand_disp;
        mcost_d = cand_cost;
        if (!cost_last) begin
          len_err_d = 1'b1;
        end
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_q + DISP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      best_cost_q <= '0;
      best_disp_q <= '0;
      valid_q     <= 1'b0;
      disp_q      <= '0;
      mcost_q     <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_cost_q <= best_cost_d;
      best_disp_q <= best_disp_d;
      valid_q     <= valid_d;
      disp_q      <= disp_d;
      mcost_q     <= mcost_d;
      len_err_q   <= len_err_d;
    end
  end

  assign disp_valid = valid_q;
  assign disp       = disp_q;
  assign min_cost   = mcost_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_disparity_wta.sv
// Directed scoreboard bench: instance 0 uses default sizing, instance 1 uses
// MAX_DISP=4 to reach the overlength path.
module tb_disparity_wta;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      cv, cl, dr, crdy, dv, le;
  logic [1:0][5:0] ci, mc;
  logic [5:0]      d0;
  logic [1:0]      d1;

  int total = 0;
  int bad   = 0;
  int stall = 0;
  int pops0 = 0;
  int pops1 = 0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  always #5 clk = ~clk;

  disparity_wta dut0 (
    .clk(clk), .rst(rst),
    .cost_valid(cv[0]), .cost(ci[0]), .cost_last(cl[0]), .cost_ready(crdy[0]),
    .disp_valid(dv[0]), .disp(d0), .min_cost(mc[0]), .disp_ready(dr[0]),
    .len_err(le[0])
  );

  disparity_wta #(.COST_WIDTH(6), .MAX_DISP(4), .DISP_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst),
    .cost_valid(cv[1]), .cost(ci[1]), .cost_last(cl[1]), .cost_ready(crdy[1]),
    .disp_valid(dv[1]), .disp(d1), .min_cost(mc[1]), .disp_ready(dr[1]),
    .len_err(le[1])
  );

  // Monitor: a result is consumed at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if (dv[i] && dr[i]) begin
          logic [11:0] act, exp;
          act = (i == 0) ? {d0, mc[0]} : {4'b0, d1, mc[1]};
          total++;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_result dut%0d got disp=%0d min_cost=%0d required none",
                     i, act[11:6], act[5:0]);
          end else begin
            exp = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (act !== exp) begin
              bad++;
              $display("FAIL result dut%0d got disp=%0d min_cost=%0d required disp=%0d min_cost=%0d",
                       i, act[11:6], act[5:0], exp[11:6], exp[5:0]);
            end else begin
              $display("txn dut%0d disp=%0d min_cost=%0d", i, act[11:6], act[5:0]);
            end
          end
          if (i == 0) pops0++; else pops1++;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic expect_res(input int i, input int dsp, input int c);
    logic [11:0] e;
    e = {dsp[5:0], c[5:0]};
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepts it.
  task automatic beat(input int i, input logic [5:0] c, input logic l);
    cv[i] = 1'b1;
    ci[i] = c;
    cl[i] = l;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (crdy[i]) break;
      stall++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL beat_timeout dut%0d got cost_ready=0 required 1", i);
        break;
      end
    end
    @(posedge clk);
    #1;
    cv[i] = 1'b0;
    cl[i] = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    rst = 1'b0;
    cv  = '0;
    cl  = '0;
    ci  = '0;
    dr  = 2'b11;

    // Reset state
    repeat (3) cycle();
    @(negedge clk);
    chk("rst_disp_valid", dv[0], 0);
    chk("rst_disp", d0, 0);
    chk("rst_min_cost", mc[0], 0);
    chk("rst_len_err", le[0], 0);
    cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("cost_ready_after_rst", crdy[0], 1);
    cycle();

    // Main pixel, one-cycle latency and exactly one result
    p = pops0;
    beat(0, 6'd9, 0); beat(0, 6'd4, 0); beat(0, 6'd7, 0);
    beat(0, 6'd4, 0); beat(0, 6'd2, 0);
    expect_res(0, 4, 2);
    beat(0, 6'd5, 1);
    chk("latency_valid", dv[0], 1);
    cycle();
    chk("valid_falls", dv[0], 0);
    chk("one_result", pops0 - p, 1);

    // Ties keep the lower index; back-to-back pixels with a drain overlap
    beat(0, 6'd3, 0); beat(0, 6'd3, 0);
    expect_res(0, 0, 3);
    beat(0, 6'd3, 1);
    beat(0, 6'd5, 0); beat(0, 6'd1, 0);
    expect_res(0, 1, 1);
    beat(0, 6'd1, 1);
    cycle();

    // Single-beat pixels every cycle
    p = pops0;
    stall = 0;
    expect_res(0, 0, 17);
    beat(0, 6'd17, 1);
    for (int k = 0; k < 8; k++) begin
      expect_res(0, 0, k * 3 + 1);
      beat(0, 6'(k * 3 + 1), 1);
    end
    chk("no_stall_b2b", stall, 0);
    cycle();
    cycle();
    chk("b2b_results", pops0 - p, 9);

    // Back-pressure: hold the result for 10 cycles
    dr[0] = 1'b0;
    beat(0, 6'd20, 0);
    expect_res(0, 1, 10);
    beat(0, 6'd10, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_cost_ready", crdy[0], 0);
      chk("bp_disp", d0, 1);
      chk("bp_min_cost", mc[0], 10);
      chk("bp_valid", dv[0], 1);
    end
    cycle();
    dr[0] = 1'b1;
    stall = 0;
    expect_res(0, 0, 6);
    beat(0, 6'd6, 1);
    chk("accept_on_ready_rise", stall, 0);
    chk("drain_and_load_valid", dv[0], 1);
    cycle();

    // Overlength on the MAX_DISP=4 instance
    beat(1, 6'd8, 0); beat(1, 6'd6, 0); beat(1, 6'd9, 0);
    expect_res(1, 3, 1);
    beat(1, 6'd1, 0);
    chk("ovl_valid", dv[1], 1);
    chk("ovl_len_err", le[1], 1);
    beat(1, 6'd0, 0); beat(1, 6'd3, 0);
    expect_res(1, 0, 0);
    beat(1, 6'd5, 1);
    beat(1, 6'd7, 0);
    expect_res(1, 1, 2);
    beat(1, 6'd2, 1);
    cycle();
    chk("len_err_sticky", le[1], 1);

    // Reset mid-pixel discards the partial pixel and clears len_err
    beat(0, 6'd30, 0); beat(0, 6'd1, 0); beat(0, 6'd0, 0);
    rst = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    chk("midrst_valid", dv[0], 0);
    chk("midrst_len_err1", le[1], 0);
    cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cost_ready", crdy[0], 1);
    cycle();
    beat(0, 6'd2, 0);
    expect_res(0, 0, 2);
    beat(0, 6'd7, 1);
    cycle();
    chk("midrst_len_err0", le[0], 0);
    cycle();

    chk("queue0_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
